packetizer_n: RTL and testbench
===============================

# packetizer_n

Multi-flit packetizer: accepts one wide data word plus destination per valid/ready transaction and serialises it into 1..N NoC flits with proper valid/head/tail/VC/destination headers. It is the parametrised successor of the single-flit packetizer. It sits between a module's output port and the NoC router injection port. The flit count is derived from the parameters, and output flits are registered.

## Interface
Parameters:
- ADDRESS_WIDTH, 4, router destination address width
- VC_ADDRESS_WIDTH, 1, virtual-channel field width
- WIDTH_IN, 80, payload word width
- WIDTH_OUT, 36, flit width
- ASSIGNED_VC, 0 (VC_ADDRESS_WIDTH bits), VC used for packets (start VC in round-robin mode)

Derived localparams:
- HEAD_PAYLOAD = WIDTH_OUT-3-VC_ADDRESS_WIDTH-ADDRESS_WIDTH (28 at default)
- BODY_PAYLOAD = WIDTH_OUT-3-VC_ADDRESS_WIDTH (32 at default)
- NUM_FLITS = 1 if WIDTH_IN<=HEAD_PAYLOAD, else 1+ceil((WIDTH_IN-HEAD_PAYLOAD)/BODY_PAYLOAD) (3 at default)
- Elaboration error if HEAD_PAYLOAD<1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  WIDTH_IN  payload word
- valid_in  in  1  input word valid
- dst_in  in  ADDRESS_WIDTH  destination router
- ready_out  out  1  packetizer can accept a word this cycle
- data_out  out  WIDTH_OUT  flit
- valid_out  out  1  flit valid
- ready_in  in  1  downstream accepts flit this cycle

## Operation
- Head flit format, MSB to LSB: {1'b1 valid, 1'b1 head, tail, vc, dst, payload[HEAD_PAYLOAD], zero pad}.
- Body/tail flit format: {1'b1, 1'b0, tail, vc, payload[BODY_PAYLOAD], zero pad}.
- Payload is sliced MSB-first. The head flit takes data_in[WIDTH_IN-1 -: HEAD_PAYLOAD]. Each following flit takes the next BODY_PAYLOAD bits.
- Only the last flit can be short. Its payload is left-aligned, and the LSBs are zero-padded.
- tail=1 only on flit NUM_FLITS-1. When NUM_FLITS=1, the single flit has head=tail=1.
- The word and dst are captured into a holding register on the accept (valid_in & ready_out). The vc value is latched per packet.
- FSM:
  - IDLE: valid_out=0, ready_out=1. An accept moves to SEND with flit_cnt=0.
  - SEND: valid_out=1, data_out=flit[flit_cnt]. When ready_in is high, flit_cnt increments.
  - On the tail handshake, the FSM returns to IDLE, unless a new word is accepted in the same cycle, in which case it stays in SEND with flit_cnt=0.
- ready_out = IDLE | (SEND & tail flit & ready_in). This is a combinational path from ready_in.
- ready_in while valid_out=0 is ignored. valid_in while ready_out=0 is not consumed; the upstream holds it.

## Timing
- Reset values: valid_out=0, data_out=0, FSM=IDLE, flit_cnt=0, vc pointer=ASSIGNED_VC. ready_out=1 once rst_n is high.
- Latency: accept at edge T; head flit presented from after edge T until its handshake.
- Throughput: NUM_FLITS cycles per packet with ready_in held high, and no bubbles between back-to-back packets.
- data_out and valid_out are stable while valid_out=1 and ready_in=0.
- Reset mid-packet: outputs clear asynchronously. The partial packet is dropped with no tail sent. The next packet starts with a head flit.
- Simultaneous tail handshake and new accept: the new head flit is presented in the very next cycle.

## Configuration
- PACKETIZER_N_VC_RR_EN defined: the vc pointer advances by 1 (mod 2^VC_ADDRESS_WIDTH) on each accepted packet. The first packet after reset uses ASSIGNED_VC. All flits of a packet share its vc.
- Undefined: every packet uses ASSIGNED_VC, and the vc pointer logic is absent.

## Test plan
- Basic, default params, ready_in=1: dst_in=4'h5, data_in={28'hABCDEF1,32'h12345678,20'h9ABCD} -> flits 36'hC5ABCDEF1, 36'h812345678, 36'hA9ABCD000 on 3 consecutive cycles. ready_out=0 for the first two of those cycles.
- Backpressure: drop ready_in for 3 cycles while the body flit is shown -> data_out stays 36'h812345678, valid_out=1, ready_out=0. The tail follows one cycle after ready_in rises.
- Back-to-back: valid_in held for two packets, ready_in=1 -> 6 flits in 6 consecutive cycles. ready_out=1 only in the cycle the first tail handshakes. The second head carries the second dst.
- Reset mid-packet: assert rst_n low after the head handshake -> valid_out=0 immediately. After release, a new packet emits head, body, tail, with no stale tail from the dropped packet.
- VC round-robin: VC_ADDRESS_WIDTH=2, ASSIGNED_VC=1, 5 packets -> with the macro defined, vc fields are 1,2,3,0,1; without it, all are 1.
- Single-flit config: WIDTH_IN=20 (NUM_FLITS=1), dst=4'h3, data 20'hFEDCB -> flit 36'hE3FEDCB00 (head=tail=1, 8 pad bits). Packets are accepted every cycle.

Source files
------------

// File: rtl/packetizer_n.sv
// -----------------------------------------------------------------------------
// packetizer_n
//   Serialises one wide payload word plus a destination address into
//   NUM_FLITS NoC flits (head, optional body flits, tail). Sits between a
//   module's output port and a router injection port.
//
//   Head flit : {1'b1, 1'b1, tail, vc, dst, payload[HEAD_PAYLOAD]}
//   Body/tail : {1'b1, 1'b0, tail, vc, payload[BODY_PAYLOAD]}
//   The payload is taken MSB-first. The last flit is left-aligned and
//   zero-padded in its LSBs.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   data_in   : payload word (WIDTH_IN)
//   valid_in  : payload word valid
//   dst_in    : destination router address (ADDRESS_WIDTH)
//   ready_out : a word can be accepted this cycle (combinational from ready_in)
//   data_out  : registered flit (WIDTH_OUT)
//   valid_out : registered flit valid
//   ready_in  : downstream accepts the flit this cycle
//
// Configuration
//   PACKETIZER_N_VC_RR_EN : when defined, every accepted packet advances the
//                           VC pointer by one, starting from ASSIGNED_VC.
//                           When undefined, every packet uses ASSIGNED_VC.
// -----------------------------------------------------------------------------
module packetizer_n #(
   parameter int ADDRESS_WIDTH    = 4,
   parameter int VC_ADDRESS_WIDTH = 1,
   parameter int WIDTH_IN         = 80,
   parameter int WIDTH_OUT        = 36,
   parameter logic [VC_ADDRESS_WIDTH-1:0] ASSIGNED_VC = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH_IN-1:0]      data_in,
   input  logic                     valid_in,
   input  logic [ADDRESS_WIDTH-1:0] dst_in,
   output logic                     ready_out,
   output logic [WIDTH_OUT-1:0]     data_out,
   output logic                     valid_out,
   input  logic                     ready_in
);

   localparam int VCW          = VC_ADDRESS_WIDTH;
   localparam int HEAD_PAYLOAD = WIDTH_OUT - 3 - VCW - ADDRESS_WIDTH;
   localparam int BODY_PAYLOAD = WIDTH_OUT - 3 - VCW;
   localparam int NUM_FLITS    = (WIDTH_IN <= HEAD_PAYLOAD) ? 1 :
      1 + (WIDTH_IN - HEAD_PAYLOAD + BODY_PAYLOAD - 1) / BODY_PAYLOAD;
   localparam int CNT_W        = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
   // One spare BODY_PAYLOAD of zeros below the real payload keeps every
   // slice base in range, including the look-ahead index past the tail.
   localparam int PAD_W        = HEAD_PAYLOAD + NUM_FLITS * BODY_PAYLOAD;

   if (HEAD_PAYLOAD < 1) begin : g_bad_width
      $error("packetizer_n: WIDTH_OUT too small to hold a head flit payload");
   end

   typedef enum logic {IDLE, SEND} state_t;

   state_t                     state_q;
   logic [CNT_W-1:0]           cnt_q;
   logic                       valid_out_q;
   logic [WIDTH_OUT-1:0]       data_out_q;
   logic [WIDTH_IN-1:0]        data_q;
   logic [ADDRESS_WIDTH-1:0]   dst_q;
   logic [VCW-1:0]             vc_new;
   logic [VCW-1:0]             vc_cur;
   logic [WIDTH_OUT-1:0]       next_flit_d;
   logic                       last_flit;
   logic                       accept;

   function automatic logic [WIDTH_OUT-1:0] build_flit(
      input logic [WIDTH_IN-1:0]      word,
      input logic [ADDRESS_WIDTH-1:0] dst,
      input logic [VCW-1:0]           vc,
      input logic [CNT_W-1:0]         idx
   );
      logic [PAD_W-1:0] padded;
      logic             tail;
      int               base;
      padded = '0;
      padded[PAD_W-1 -: WIDTH_IN] = word;
      tail = (int'(idx) == NUM_FLITS - 1);
      base = PAD_W - 1 - HEAD_PAYLOAD - (int'(idx) - 1) * BODY_PAYLOAD;
      if (idx == '0)
         build_flit = {2'b11, tail, vc, dst, padded[PAD_W-1 -: HEAD_PAYLOAD]};
      else
         build_flit = {2'b10, tail, vc, padded[base -: BODY_PAYLOAD]};
   endfunction

   assign last_flit = (cnt_q == CNT_W'(NUM_FLITS - 1));
   assign ready_out = (state_q == IDLE) | ((state_q == SEND) & last_flit & ready_in);
   assign accept    = valid_in & ready_out;
   assign valid_out = valid_out_q;
   assign data_out  = data_out_q;

`ifdef PACKETIZER_N_VC_RR_EN
   logic [VCW-1:0] vc_ptr_q;
   logic [VCW-1:0] pkt_vc_q;

   // vc_ptr_q is the VC the next packet will use; pkt_vc_q is the VC of the
   // packet currently being sent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vc_ptr_q <= ASSIGNED_VC;
         pkt_vc_q <= ASSIGNED_VC;
      end else if (accept) begin
         vc_ptr_q <= vc_ptr_q + 1'b1;
         pkt_vc_q <= vc_ptr_q;
      end
   end

   assign vc_new = vc_ptr_q;
   assign vc_cur = pkt_vc_q;
`else
   assign vc_new = ASSIGNED_VC;
   assign vc_cur = ASSIGNED_VC;
`endif

   // Holding register: payload and destination of the packet in flight.
   always_ff @(posedge clk) begin
      if (accept) begin
         data_q <= data_in;
         dst_q  <= dst_in;
      end
   end

   // The next flit comes straight from the inputs on an accept (new head),
   // otherwise it is the following slice of the held word.
   always_comb begin
      next_flit_d = '0;
      if (accept)
         next_flit_d = build_flit(data_in, dst_in, vc_new, '0);
      else
         next_flit_d = build_flit(data_q, dst_q, vc_cur, cnt_q + 1'b1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         valid_out_q <= 1'b0;
         data_out_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q     <= SEND;
                  cnt_q       <= '0;
                  valid_out_q <= 1'b1;
                  data_out_q  <= next_flit_d;
               end
            end
            SEND: begin
               if (ready_in) begin
                  if (last_flit) begin
                     cnt_q <= '0;
                     if (accept) begin
                        data_out_q <= next_flit_d;
                     end else begin
                        state_q     <= IDLE;
                        valid_out_q <= 1'b0;
                        data_out_q  <= '0;
                     end
                  end else begin
                     cnt_q      <= cnt_q + 1'b1;
                     data_out_q <= next_flit_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_packetizer_n.sv
// -----------------------------------------------------------------------------
// tb_packetizer_n
//   Two packetizer instances sharing clock and reset:
//     uA : default parameters (80-bit word -> 3 flits, 1-bit VC, ASSIGNED_VC=0)
//     uB : 20-bit word -> single flit, 2-bit VC, ASSIGNED_VC=1
//   Stimulus pushes expected flits into per-instance queues; a negedge monitor
//   per instance compares every presented flit against the queue head and
//   pops on handshake.
// -----------------------------------------------------------------------------
module tb_packetizer_n;

   localparam int AW    = 4;
   localparam int A_WIN = 80;
   localparam int A_VCW = 1;
   localparam int A_VC  = 0;
   localparam int B_WIN = 20;
   localparam int B_VCW = 2;
   localparam int B_VC  = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [79:0] a_data;
   logic        a_valid;
   logic [3:0]  a_dst;
   logic        a_rdy_o;
   logic [35:0] a_dout;
   logic        a_vout;
   logic        a_rdy_i;

   logic [19:0] b_data;
   logic        b_valid;
   logic [3:0]  b_dst;
   logic        b_rdy_o;
   logic [35:0] b_dout;
   logic        b_vout;
   logic        b_rdy_i;

   int          total = 0;
   int          bad = 0;
   logic [35:0] qa[$];
   logic [35:0] qb[$];
   int          pkta = 0;
   int          pktb = 0;
   logic        bp_a = 1'b0;
   logic        bp_b = 1'b0;

   always #5 clk = ~clk;

   packetizer_n #(
      .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(A_VCW), .WIDTH_IN(A_WIN),
      .WIDTH_OUT(36), .ASSIGNED_VC(1'b0)
   ) uA (
      .clk(clk), .rst_n(rst_n), .data_in(a_data), .valid_in(a_valid),
      .dst_in(a_dst), .ready_out(a_rdy_o), .data_out(a_dout),
      .valid_out(a_vout), .ready_in(a_rdy_i)
   );

   packetizer_n #(
      .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(B_VCW), .WIDTH_IN(B_WIN),
      .WIDTH_OUT(36), .ASSIGNED_VC(2'd1)
   ) uB (
      .clk(clk), .rst_n(rst_n), .data_in(b_data), .valid_in(b_valid),
      .dst_in(b_dst), .ready_out(b_rdy_o), .data_out(b_dout),
      .valid_out(b_vout), .ready_in(b_rdy_i)
   );

   // ---------------- reference model ----------------
   function automatic int nflits(int win, int vcw);
      int hp = 36 - 3 - vcw - AW;
      int bp = 36 - 3 - vcw;
      if (win <= hp) return 1;
      return 1 + (win - hp + bp - 1) / bp;
   endfunction

   function automatic int pkt_vc(int base, int vcw, int n);
`ifdef PACKETIZER_N_VC_RR_EN
      return (base + n) % (1 << vcw);
`else
      return base + 0 * n + 0 * vcw;
`endif
   endfunction

   // Flit k of a packet, assembled bit by bit from MSB downwards.
   function automatic logic [35:0] mk_flit(logic [79:0] data, int win, int vcw,
                                           int dst, int vc, int k, int nfl);
      logic [35:0] f;
      int p, start, len, pos;
      int hp = 36 - 3 - vcw - AW;
      int bp = 36 - 3 - vcw;
      f = '0;
      f[35] = 1'b1;
      f[34] = (k == 0);
      f[33] = (k == nfl - 1);
      p = 32;
      for (int i = 0; i < vcw; i++) begin
         f[p] = 1'((vc >> (vcw - 1 - i)) & 1);
         p--;
      end
      if (k == 0) begin
         for (int i = 0; i < AW; i++) begin
            f[p] = 1'((dst >> (AW - 1 - i)) & 1);
            p--;
         end
         start = 0;
         len = hp;
      end else begin
         start = hp + (k - 1) * bp;
         len = bp;
      end
      for (int i = 0; i < len; i++) begin
         pos = start + i;
         f[p] = (pos < win) ? data[win - 1 - pos] : 1'b0;
         p--;
      end
      return f;
   endfunction

   task automatic push_a(logic [79:0] d, logic [3:0] dst);
      int n = nflits(A_WIN, A_VCW);
      int vc = pkt_vc(A_VC, A_VCW, pkta);
      for (int k = 0; k < n; k++) qa.push_back(mk_flit(d, A_WIN, A_VCW, int'(dst), vc, k, n));
      pkta++;
   endtask

   task automatic push_b(logic [19:0] d, logic [3:0] dst);
      int n = nflits(B_WIN, B_VCW);
      int vc = pkt_vc(B_VC, B_VCW, pktb);
      for (int k = 0; k < n; k++)
         qb.push_back(mk_flit({60'b0, d}, B_WIN, B_VCW, int'(dst), vc, k, n));
      pktb++;
   endtask

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rst_n && a_vout) begin
         if (qa.size() == 0) begin
            total++;
            bad++;
            $display("FAIL a_unexpected_flit: got %0h expected no flit", a_dout);
         end else begin
            check("a_flit", 64'(a_dout), 64'(qa[0]));
            if (a_rdy_i) void'(qa.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_vout) begin
         if (qb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_unexpected_flit: got %0h expected no flit", b_dout);
         end else begin
            check("b_flit", 64'(b_dout), 64'(qb[0]));
            if (b_rdy_i) void'(qb.pop_front());
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (bp_a) a_rdy_i = ($urandom_range(0, 3) != 0);
      if (bp_b) b_rdy_i = ($urandom_range(0, 3) != 0);
   endtask

   function automatic logic [79:0] rand80();
      logic [79:0] d;
      d[79:64] = 16'($urandom());
      d[63:32] = $urandom();
      d[31:0]  = $urandom();
      return d;
   endfunction

   task automatic send_a(logic [79:0] d, logic [3:0] dst, output int waits);
      logic done = 1'b0;
      a_data = d;
      a_dst = dst;
      a_valid = 1'b1;
      waits = 0;
      while (!done) begin
         @(negedge clk);
         if (a_rdy_o) begin
            push_a(d, dst);
            done = 1'b1;
         end else if (waits >= 200) begin
            total++;
            bad++;
            $display("FAIL a_accept_timeout: got no ready_out expected ready within 200 cycles");
            done = 1'b1;
            a_valid = 1'b0;
         end else begin
            tick();
            waits++;
         end
      end
      if (a_valid) tick();
      a_valid = 1'b0;
   endtask

   task automatic send_b(logic [19:0] d, logic [3:0] dst, output int waits);
      logic done = 1'b0;
      b_data = d;
      b_dst = dst;
      b_valid = 1'b1;
      waits = 0;
      while (!done) begin
         @(negedge clk);
         if (b_rdy_o) begin
            push_b(d, dst);
            done = 1'b1;
         end else if (waits >= 200) begin
            total++;
            bad++;
            $display("FAIL b_accept_timeout: got no ready_out expected ready within 200 cycles");
            done = 1'b1;
            b_valid = 1'b0;
         end else begin
            tick();
            waits++;
         end
      end
      if (b_valid) tick();
      b_valid = 1'b0;
   endtask

   task automatic drain(string name);
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
         tick();
         n++;
      end
      check({name, "_qa_empty"}, 64'(qa.size()), 64'd0);
      check({name, "_qb_empty"}, 64'(qb.size()), 64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [79:0] w0;
      int w;
      w0 = {28'hABCDEF1, 32'h12345678, 20'h9ABCD};
      a_data = '0; a_valid = 1'b0; a_dst = '0; a_rdy_i = 1'b1;
      b_data = '0; b_valid = 1'b0; b_dst = '0; b_rdy_i = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid_out", 64'(a_vout), 64'd0);
      check("rst_data_out", 64'(a_dout), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_ready_out", 64'(a_rdy_o), 64'd1);
      check("rst_b_valid_out", 64'(b_vout), 64'd0);
      tick();

      // Basic three-flit packet with ready_in held high.
      send_a(w0, 4'h5, w);
      check("basic_wait", 64'(w), 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("basic_valid", 64'(a_vout), 64'd1);
         check("basic_ready_out", 64'(a_rdy_o), (k == 2) ? 64'd1 : 64'd0);
         if (k == 0) check("basic_head", 64'(a_dout), 64'h0C5ABCDEF1);
         if (k == 1) check("basic_body", 64'(a_dout), 64'h0812345678);
         if (k == 2) check("basic_tail", 64'(a_dout), 64'h0A9ABCD000);
         tick();
      end
      @(negedge clk);
      check("basic_idle_valid", 64'(a_vout), 64'd0);
      tick();

      // Backpressure on the body flit.
      send_a(w0, 4'h5, w);
      tick();
      a_rdy_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_valid", 64'(a_vout), 64'd1);
         check("bp_ready_out", 64'(a_rdy_o), 64'd0);
         check("bp_body_payload", 64'(a_dout[31:0]), 64'h12345678);
         tick();
      end
      a_rdy_i = 1'b1;
      tick();
      @(negedge clk);
      check("bp_tail_payload", 64'(a_dout[31:0]), 64'h9ABCD000);
      check("bp_tail_flag", 64'(a_dout[35:33]), 64'b101);
      tick();
      tick();

      // Back-to-back packets with valid_in held.
      send_a(rand80(), 4'h9, w);
      send_a(rand80(), 4'hA, w);
      check("b2b_wait", 64'(w), 64'd2);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("b2b_valid", 64'(a_vout), 64'd1);
         if (k == 0) check("b2b_head_dst", 64'(a_dout[31:28]), 64'hA);
         tick();
      end
      drain("b2b");

      // Reset in the middle of a packet.
      send_a(rand80(), 4'h7, w);
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 64'(a_vout), 64'd0);
      check("midrst_data", 64'(a_dout), 64'd0);
      qa.delete();
      qb.delete();
      pkta = 0;
      pktb = 0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send_a(rand80(), 4'h2, w);
      repeat (4) tick();
      check("midrst_after_qa", 64'(qa.size()), 64'd0);

      // Randomised traffic with random backpressure on A.
      bp_a = 1'b1;
      for (int i = 0; i < 150; i++) begin
         send_a(rand80(), 4'($urandom()), w);
         repeat ($urandom_range(0, 2)) tick();
      end
      bp_a = 1'b0;
      a_rdy_i = 1'b1;
      drain("rand_a");

      // Single-flit instance: one packet per cycle, VC sequence.
      send_b(20'hFEDCB, 4'h3, w);
      check("b_first_wait", 64'(w), 64'd0);
      for (int i = 0; i < 4; i++) begin
         send_b(20'($urandom()), 4'($urandom()), w);
         check("b_every_cycle", 64'(w), 64'd0);
      end
      drain("b_dir");

      bp_b = 1'b1;
      for (int i = 0; i < 60; i++) begin
         send_b(20'($urandom()), 4'($urandom()), w);
         repeat ($urandom_range(0, 1)) tick();
      end
      bp_b = 1'b0;
      b_rdy_i = 1'b1;
      drain("rand_b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
